// File: rtl/mips_pkg.sv
// mips_pkg: shared ALU op codes, instruction field positions and register helpers.
// Rev 1.0
`default_nettype none

package mips_pkg;

  typedef enum logic [3:0] {
    ALU_AND = 4'b0000,
    ALU_OR  = 4'b0001,
    ALU_ADD = 4'b0010,
    ALU_SUB = 4'b0110,
    ALU_SLT = 4'b0111,
    ALU_NOR = 4'b1100
  } alu_op_e;

  localparam int RS_MSB = 25;
  localparam int RS_LSB = 21;
  localparam int RT_MSB = 20;
  localparam int RT_LSB = 16;
  localparam int RD_MSB = 15;
  localparam int RD_LSB = 11;

  localparam logic [4:0] REG_ZERO = 5'd0;

  function automatic logic [4:0] rs_of(input logic [31:0] instr);
    return instr[RS_MSB:RS_LSB];
  endfunction

  function automatic logic [4:0] rt_of(input logic [31:0] instr);
    return instr[RT_MSB:RT_LSB];
  endfunction

  function automatic logic [4:0] rd_of(input logic [31:0] instr);
    return instr[RD_MSB:RD_LSB];
  endfunction

  function automatic logic [4:0] dest_reg(input logic [31:0] instr, input logic regdst);
    return regdst ? rd_of(instr) : rt_of(instr);
  endfunction

endpackage

`default_nettype wire

// File: rtl/id_ex_stage_if.sv
// id_ex_stage_if: ID-side inputs, forwarding sources and EX-side outputs of the ID/EX register.
// Rev 1.0
`default_nettype none

interface id_ex_stage_if #(
  parameter int WIDTH = 32
) ();

  logic             id_valid;
  logic [WIDTH-1:0] id_read1;
  logic [WIDTH-1:0] id_read2;
  logic [31:0]      id_instru;
  logic             id_alusrc;
  logic [3:0]       id_aluctrl;
  logic             id_regdst;
  logic             id_regwrite;
  logic             id_memread;
  logic             id_memwrite;
  logic             id_memtoreg;
  logic             id_branch;

  logic             stall;
  logic             flush;

  logic             exmem_regwrite;
  logic [4:0]       exmem_rd;
  logic [WIDTH-1:0] exmem_result;
  logic             memwb_regwrite;
  logic [4:0]       memwb_rd;
  logic [WIDTH-1:0] memwb_result;

  logic             ex_valid;
  logic [WIDTH-1:0] ex_data1;
  logic [WIDTH-1:0] ex_read2;
  logic [31:0]      ex_instru;
  logic             ex_alusrc;
  logic [3:0]       ex_aluctrl;
  logic [4:0]       ex_wreg;
  logic             ex_regwrite;
  logic             ex_memread;
  logic             ex_memwrite;
  logic             ex_memtoreg;
  logic             ex_branch;
  logic             hazard;

  modport master (
    output id_valid, id_read1, id_read2, id_instru, id_alusrc, id_aluctrl, id_regdst,
           id_regwrite, id_memread, id_memwrite, id_memtoreg, id_branch,
           stall, flush,
           exmem_regwrite, exmem_rd, exmem_result, memwb_regwrite, memwb_rd, memwb_result,
    input  ex_valid, ex_data1, ex_read2, ex_instru, ex_alusrc, ex_aluctrl, ex_wreg,
           ex_regwrite, ex_memread, ex_memwrite, ex_memtoreg, ex_branch, hazard
  );

  modport slave (
    input  id_valid, id_read1, id_read2, id_instru, id_alusrc, id_aluctrl, id_regdst,
           id_regwrite, id_memread, id_memwrite, id_memtoreg, id_branch,
           stall, flush,
           exmem_regwrite, exmem_rd, exmem_result, memwb_regwrite, memwb_rd, memwb_result,
    output ex_valid, ex_data1, ex_read2, ex_instru, ex_alusrc, ex_aluctrl, ex_wreg,
           ex_regwrite, ex_memread, ex_memwrite, ex_memtoreg, ex_branch, hazard
  );

endinterface

`default_nettype wire

// File: rtl/fwd_mux.sv
// fwd_mux: two-source priority operand forwarder (EX/MEM over MEM/WB, never register 0).
// Rev 1.0
`default_nettype none

module fwd_mux
  import mips_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             en,
  input  logic [4:0]       src,
  input  logic [WIDTH-1:0] reg_val,
  input  logic             exmem_regwrite,
  input  logic [4:0]       exmem_rd,
  input  logic [WIDTH-1:0] exmem_result,
  input  logic             memwb_regwrite,
  input  logic [4:0]       memwb_rd,
  input  logic [WIDTH-1:0] memwb_result,
  output logic [WIDTH-1:0] data
);

  always_comb begin
    data = reg_val;
    // src != 0 together with rd == src also excludes a zero destination
    if (en && (src != REG_ZERO)) begin
      if (exmem_regwrite && (exmem_rd == src)) begin
        data = exmem_result;
      end else if (memwb_regwrite && (memwb_rd == src)) begin
        data = memwb_result;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register with operand forwarding and load-use hazard detection.
// Rev 1.0
`default_nettype none

module id_ex_stage
  import mips_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter bit FWD_EN = 1'b1
) (
  input  logic          clk,
  input  logic          rst_n,
  id_ex_stage_if.slave  bus
);

  logic             r_valid;
  logic [WIDTH-1:0] r_read1;
  logic [WIDTH-1:0] r_read2;
  logic [31:0]      r_instru;
  logic             r_alusrc;
  logic [3:0]       r_aluctrl;
  logic [4:0]       r_wreg;
  logic             r_regwrite;
  logic             r_memread;
  logic             r_memwrite;
  logic             r_memtoreg;
  logic             r_branch;

  logic             w_hazard;
  logic             w_fwd_en;

  assign w_hazard = r_valid && r_memread && (r_wreg != REG_ZERO) &&
                    ((r_wreg == rs_of(bus.id_instru)) || (r_wreg == rt_of(bus.id_instru))) &&
                    bus.id_valid;

  always_ff @(posedge clk) begin
    if (!rst_n || (!bus.stall && (bus.flush || w_hazard))) begin
      r_valid    <= 1'b0;
      r_read1    <= '0;
      r_read2    <= '0;
      r_instru   <= '0;
      r_alusrc   <= 1'b0;
      r_aluctrl  <= '0;
      r_wreg     <= REG_ZERO;
      r_regwrite <= 1'b0;
      r_memread  <= 1'b0;
      r_memwrite <= 1'b0;
      r_memtoreg <= 1'b0;
      r_branch   <= 1'b0;
    end else if (!bus.stall) begin
      r_valid    <= bus.id_valid;
      r_read1    <= bus.id_read1;
      r_read2    <= bus.id_read2;
      r_instru   <= bus.id_instru;
      r_alusrc   <= bus.id_alusrc;
      r_aluctrl  <= bus.id_aluctrl;
      r_wreg     <= dest_reg(bus.id_instru, bus.id_regdst);
      r_regwrite <= bus.id_regwrite & bus.id_valid;
      r_memread  <= bus.id_memread  & bus.id_valid;
      r_memwrite <= bus.id_memwrite & bus.id_valid;
      r_memtoreg <= bus.id_memtoreg & bus.id_valid;
      r_branch   <= bus.id_branch   & bus.id_valid;
    end
  end

  // Forwarding also covers the B source when alusrc selects the immediate, so store data is right
  assign w_fwd_en = FWD_EN && r_valid;

  fwd_mux #(.WIDTH(WIDTH)) u_fwd_a (
    .en             (w_fwd_en),
    .src            (rs_of(r_instru)),
    .reg_val        (r_read1),
    .exmem_regwrite (bus.exmem_regwrite),
    .exmem_rd       (bus.exmem_rd),
    .exmem_result   (bus.exmem_result),
    .memwb_regwrite (bus.memwb_regwrite),
    .memwb_rd       (bus.memwb_rd),
    .memwb_result   (bus.memwb_result),
    .data           (bus.ex_data1)
  );

  fwd_mux #(.WIDTH(WIDTH)) u_fwd_b (
    .en             (w_fwd_en),
    .src            (rt_of(r_instru)),
    .reg_val        (r_read2),
    .exmem_regwrite (bus.exmem_regwrite),
    .exmem_rd       (bus.exmem_rd),
    .exmem_result   (bus.exmem_result),
    .memwb_regwrite (bus.memwb_regwrite),
    .memwb_rd       (bus.memwb_rd),
    .memwb_result   (bus.memwb_result),
    .data           (bus.ex_read2)
  );

  assign bus.ex_valid    = r_valid;
  assign bus.ex_instru   = r_instru;
  assign bus.ex_alusrc   = r_alusrc;
  assign bus.ex_aluctrl  = r_aluctrl;
  assign bus.ex_wreg     = r_wreg;
  assign bus.ex_regwrite = r_regwrite;
  assign bus.ex_memread  = r_memread;
  assign bus.ex_memwrite = r_memwrite;
  assign bus.ex_memtoreg = r_memtoreg;
  assign bus.ex_branch   = r_branch;
  assign bus.hazard      = w_hazard;

endmodule

`default_nettype wire

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: directed vectors plus a per-cycle behavioural model of the ID/EX register.
// Rev 1.0
`default_nettype none

module tb_id_ex_stage;

  logic clk;
  logic rst_n;
  logic chk_en;
  int   checks;
  int   failures;

  id_ex_stage_if #(.WIDTH(32)) bus ();

  id_ex_stage #(.WIDTH(32), .FWD_EN(1'b1)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // The model stores the raw ID snapshot in EX; every output is derived from it on demand
  typedef struct {
    logic        valid;
    logic [31:0] r1, r2, instr;
    logic        alusrc;
    logic [3:0]  ctrl;
    logic        regdst, rw, mr, mw, mtr, br;
  } ex_t;

  ex_t m = '{valid: 1'b0, r1: 32'd0, r2: 32'd0, instr: 32'd0, alusrc: 1'b0, ctrl: 4'd0,
             regdst: 1'b0, rw: 1'b0, mr: 1'b0, mw: 1'b0, mtr: 1'b0, br: 1'b0};

  function automatic logic [4:0] m_wreg();
    return m.regdst ? m.instr[15:11] : m.instr[20:16];
  endfunction

  function automatic logic m_hazard();
    logic [4:0] w;
    w = m_wreg();
    return m.valid && m.mr && (w != 5'd0) && bus.id_valid &&
           ((w == bus.id_instru[25:21]) || (w == bus.id_instru[20:16]));
  endfunction

  function automatic logic [31:0] m_fwd(input logic [4:0] src, input logic [31:0] rv);
    if (!m.valid || src == 5'd0) return rv;
    if (bus.exmem_regwrite && bus.exmem_rd == src) return bus.exmem_result;
    if (bus.memwb_regwrite && bus.memwb_rd == src) return bus.memwb_result;
    return rv;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    if (!rst_n) begin
      m <= '{valid: 1'b0, r1: 32'd0, r2: 32'd0, instr: 32'd0, alusrc: 1'b0, ctrl: 4'd0,
             regdst: 1'b0, rw: 1'b0, mr: 1'b0, mw: 1'b0, mtr: 1'b0, br: 1'b0};
    end else if (bus.stall) begin
      m <= m;
    end else if (bus.flush || m_hazard()) begin
      m <= '{valid: 1'b0, r1: 32'd0, r2: 32'd0, instr: 32'd0, alusrc: 1'b0, ctrl: 4'd0,
             regdst: 1'b0, rw: 1'b0, mr: 1'b0, mw: 1'b0, mtr: 1'b0, br: 1'b0};
    end else begin
      m <= '{valid: bus.id_valid, r1: bus.id_read1, r2: bus.id_read2, instr: bus.id_instru,
             alusrc: bus.id_alusrc, ctrl: bus.id_aluctrl, regdst: bus.id_regdst,
             rw: bus.id_regwrite, mr: bus.id_memread, mw: bus.id_memwrite,
             mtr: bus.id_memtoreg, br: bus.id_branch};
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("cyc_valid",    {31'd0, bus.ex_valid},    {31'd0, m.valid});
      check("cyc_data1",    bus.ex_data1,             m_fwd(m.instr[25:21], m.r1));
      check("cyc_read2",    bus.ex_read2,             m_fwd(m.instr[20:16], m.r2));
      check("cyc_instru",   bus.ex_instru,            m.instr);
      check("cyc_alusrc",   {31'd0, bus.ex_alusrc},   {31'd0, m.alusrc});
      check("cyc_aluctrl",  {28'd0, bus.ex_aluctrl},  {28'd0, m.ctrl});
      check("cyc_wreg",     {27'd0, bus.ex_wreg},     {27'd0, m_wreg()});
      check("cyc_regwrite", {31'd0, bus.ex_regwrite}, {31'd0, m.rw  & m.valid});
      check("cyc_memread",  {31'd0, bus.ex_memread},  {31'd0, m.mr  & m.valid});
      check("cyc_memwrite", {31'd0, bus.ex_memwrite}, {31'd0, m.mw  & m.valid});
      check("cyc_memtoreg", {31'd0, bus.ex_memtoreg}, {31'd0, m.mtr & m.valid});
      check("cyc_branch",   {31'd0, bus.ex_branch},   {31'd0, m.br  & m.valid});
      check("cyc_hazard",   {31'd0, bus.hazard},      {31'd0, m_hazard()});
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_id(input logic v, input logic [31:0] r1, input logic [31:0] r2,
                        input logic [31:0] instr, input logic [3:0] ctrl, input logic regdst,
                        input logic rw, input logic mr, input logic mw, input logic mtr);
    bus.id_valid    = v;
    bus.id_read1    = r1;
    bus.id_read2    = r2;
    bus.id_instru   = instr;
    bus.id_alusrc   = 1'b0;
    bus.id_aluctrl  = ctrl;
    bus.id_regdst   = regdst;
    bus.id_regwrite = rw;
    bus.id_memread  = mr;
    bus.id_memwrite = mw;
    bus.id_memtoreg = mtr;
    bus.id_branch   = 1'b0;
  endtask

  task automatic set_fwd(input logic ew, input logic [4:0] erd, input logic [31:0] eres,
                         input logic mw, input logic [4:0] mrd, input logic [31:0] mres);
    bus.exmem_regwrite = ew;
    bus.exmem_rd       = erd;
    bus.exmem_result   = eres;
    bus.memwb_regwrite = mw;
    bus.memwb_rd       = mrd;
    bus.memwb_result   = mres;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    chk_en   = 1'b0;
    rst_n    = 1'b0;
    bus.stall = 1'b0;
    bus.flush = 1'b0;
    set_id(1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'hF, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    bus.id_alusrc = 1'b1;
    bus.id_branch = 1'b1;
    set_fwd(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);

    // Reset with every ID input high
    tick();
    chk_en = 1'b1;
    check("rst_valid",    {31'd0, bus.ex_valid},    32'd0);
    check("rst_data1",    bus.ex_data1,             32'd0);
    check("rst_read2",    bus.ex_read2,             32'd0);
    check("rst_instru",   bus.ex_instru,            32'd0);
    check("rst_wreg",     {27'd0, bus.ex_wreg},     32'd0);
    check("rst_regwrite", {31'd0, bus.ex_regwrite}, 32'd0);
    check("rst_hazard",   {31'd0, bus.hazard},      32'd0);

    // Plain load: rs=1 rt=2 rd=3, ADD
    rst_n = 1'b1;
    set_id(1'b1, 32'd5, 32'd7, 32'h0022_1820, 4'b0010, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    check("load_valid",    {31'd0, bus.ex_valid},    32'd1);
    check("load_data1",    bus.ex_data1,             32'd5);
    check("load_read2",    bus.ex_read2,             32'd7);
    check("load_aluctrl",  {28'd0, bus.ex_aluctrl},  32'd2);
    check("load_wreg",     {27'd0, bus.ex_wreg},     32'd3);
    check("load_regwrite", {31'd0, bus.ex_regwrite}, 32'd1);
    check("load_instru",   bus.ex_instru,            32'h0022_1820);

    // Forward priority: EX holds rs=4 rt=5
    set_id(1'b1, 32'h11, 32'h22, 32'h0085_3020, 4'b0010, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    bus.stall = 1'b1;
    set_fwd(1'b1, 5'd4, 32'hAA, 1'b1, 5'd4, 32'hBB);
    #1;
    check("fwd_exmem_a", bus.ex_data1, 32'hAA);
    check("fwd_none_b",  bus.ex_read2, 32'h22);
    bus.exmem_regwrite = 1'b0;
    #1;
    check("fwd_memwb_a", bus.ex_data1, 32'hBB);
    bus.memwb_rd = 5'd5;
    #1;
    check("fwd_memwb_b", bus.ex_read2, 32'hBB);
    check("fwd_reg_a",   bus.ex_data1, 32'h11);
    tick();

    // Register 0 never forwarded
    bus.stall = 1'b0;
    set_fwd(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    set_id(1'b1, 32'h33, 32'h44, 32'h0000_3820, 4'b0010, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    bus.stall = 1'b1;
    set_fwd(1'b1, 5'd0, 32'hAA, 1'b1, 5'd0, 32'hBB);
    #1;
    check("r0_data1", bus.ex_data1, 32'h33);
    check("r0_read2", bus.ex_read2, 32'h44);
    tick();

    // Load-use: lw $8 in EX, add using rt=8 in ID
    bus.stall = 1'b0;
    set_fwd(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    set_id(1'b1, 32'h1000, 32'h0, 32'h8C28_0004, 4'b0010, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
    tick();
    check("lw_wreg",    {27'd0, bus.ex_wreg},    32'd8);
    check("lw_memread", {31'd0, bus.ex_memread}, 32'd1);
    set_id(1'b1, 32'h5, 32'h6, 32'h0048_4820, 4'b0010, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    #1;
    check("lu_hazard", {31'd0, bus.hazard}, 32'd1);
    tick();
    check("lu_bub_valid",    {31'd0, bus.ex_valid},    32'd0);
    check("lu_bub_regwrite", {31'd0, bus.ex_regwrite}, 32'd0);
    check("lu_bub_memwrite", {31'd0, bus.ex_memwrite}, 32'd0);
    check("lu_bub_hazard",   {31'd0, bus.hazard},      32'd0);
    tick();
    check("lu_retry_valid", {31'd0, bus.ex_valid}, 32'd1);
    check("lu_retry_wreg",  {27'd0, bus.ex_wreg},  32'd9);

    // Flush with a valid ID instruction
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    check("fl_valid",    {31'd0, bus.ex_valid},    32'd0);
    check("fl_regwrite", {31'd0, bus.ex_regwrite}, 32'd0);
    check("fl_memwrite", {31'd0, bus.ex_memwrite}, 32'd0);
    check("fl_wreg",     {27'd0, bus.ex_wreg},     32'd0);
    check("fl_instru",   bus.ex_instru,            32'd0);

    // Stall + flush: EX holds SUB across three stalled edges, then loads AND
    set_id(1'b1, 32'h100, 32'h200, 32'h014B_6022, 4'b0110, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    set_id(1'b1, 32'h300, 32'h400, 32'h01AE_7824, 4'b0000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    bus.stall = 1'b1;
    tick();
    check("sf_hold1", bus.ex_instru, 32'h014B_6022);
    bus.flush = 1'b1;
    tick();
    check("sf_hold2",       bus.ex_instru,         32'h014B_6022);
    check("sf_hold2_valid", {31'd0, bus.ex_valid}, 32'd1);
    bus.flush = 1'b0;
    tick();
    check("sf_hold3", bus.ex_data1, 32'h100);
    bus.stall = 1'b0;
    tick();
    check("sf_release_instru", bus.ex_instru, 32'h01AE_7824);
    check("sf_release_data1",  bus.ex_data1,  32'h300);

    // Reset during stall
    bus.stall = 1'b1;
    rst_n = 1'b0;
    tick();
    check("rst_stall_valid",  {31'd0, bus.ex_valid}, 32'd0);
    check("rst_stall_instru", bus.ex_instru,         32'd0);
    rst_n = 1'b1;
    bus.stall = 1'b0;
    tick();
    tick();

    @(negedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
